vga_timing_gen: RTL

Generates 640x480@60 VGA raster timing from the 50 MHz system clock. Produces the pixel tick, the horizontal and vertical pixel counters (hcnt/vcnt) and the active-low sync pulses. hcnt/vcnt feed the downstream quadrant selector and pixel-colour logic; hsync/vsync drive the VGA connector directly.

---
 rtl/vga_timing_gen.sv | 124 ++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing (pixel tick, counters, syncs).
// Optional quadrant output is built when VGA_QUAD_EN is defined.
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HC1      = 320,
    parameter int VC1      = 240
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_tick,
    output logic [9:0] hcnt,
    output logic [9:0] vcnt,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
`ifdef VGA_QUAD_EN
    output logic       frame_start,
    output logic [1:0] quadrant
`else
    output logic       frame_start
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
`ifdef VGA_QUAD_EN
    localparam logic [9:0] H_SPLIT  = 10'(HC1);
    localparam logic [9:0] V_SPLIT  = 10'(VC1);
`endif

    logic [DW-1:0] div;
    logic [DW-1:0] div_nxt;
    logic [9:0]    h_nxt;
    logic [9:0]    v_nxt;
    logic          at_end;

    // Next divider value; wraps after CLK_DIV-1.
    always_comb begin
        div_nxt = '0;
        if (div != DIV_LAST) begin
            div_nxt = div + 1'b1;
        end
    end

    // Next raster position; only moves on a pixel tick.
    always_comb begin
        h_nxt  = hcnt;
        v_nxt  = vcnt;
        at_end = (hcnt == H_LAST) && (vcnt == V_LAST);
        if (pix_tick) begin
            if (hcnt == H_LAST) begin
                h_nxt = '0;
                if (vcnt == V_LAST) begin
                    v_nxt = '0;
                end else begin
                    v_nxt = vcnt + 10'd1;
                end
            end else begin
                h_nxt = hcnt + 10'd1;
            end
        end
    end

    // Divider and pixel tick; tick is high while divider holds its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div      <= '0;
            pix_tick <= 1'b0;
        end else begin
            div      <= div_nxt;
            pix_tick <= (div_nxt == DIV_LAST);
        end
    end

    // Counters and flags; flags decode the new position so they never lag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt        <= '0;
            vcnt        <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            hcnt        <= h_nxt;
            vcnt        <= v_nxt;
            hsync       <= !((h_nxt >= HS_BEG) && (h_nxt <= HS_END));
            vsync       <= !((v_nxt >= VS_BEG) && (v_nxt <= VS_END));
            video_on    <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
            frame_start <= pix_tick && at_end;
        end
    end

`ifdef VGA_QUAD_EN
    // Quadrant code {bottom, right}, aligned with the counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quadrant <= 2'b00;
        end else begin
            quadrant <= {v_nxt >= V_SPLIT, h_nxt >= H_SPLIT};
        end
    end
`endif

endmodule
